// File: rtl/delay_line_align.sv
// Programmable-latency delay line for a sync/counter/data bundle. Any change of
// dly_sel re-enters FILL, which blanks the outputs until the new latency has been refilled.
module delay_line_align #(
    parameter int BITWIDTH = 7,
    parameter int DATA_W   = 16,
    parameter int NCH      = 4,
    parameter int MAX_DLY  = 16,
    parameter int DLY_W    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DLY_W-1:0]        dly_sel,
    input  logic                    en_sync_in,
    input  logic [BITWIDTH+1:0]     cnt_sync_in,
    input  logic [NCH*DATA_W-1:0]   din,
    output logic                    en_sync_out,
    output logic [BITWIDTH+1:0]     cnt_sync_out,
    output logic [NCH*DATA_W-1:0]   dout,
    output logic                    dly_busy
);

    localparam int CNT_W = BITWIDTH + 2;
    localparam int DW    = NCH * DATA_W;
    localparam int TAP_W = 1 + CNT_W + DW;

    typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;

    state_t             state, next_state;
    logic [DLY_W-1:0]   dly_q;
    logic [DLY_W-1:0]   fill_cnt, fill_nxt;
    logic [DLY_W-1:0]   d_m1;
    logic               change;
    logic [TAP_W-1:0]   in_word;
    logic [TAP_W-1:0]   sel_word;
    logic [TAP_W-1:0]   tap_p0 [MAX_DLY-1];
    logic [TAP_W-1:0]   out_p1;
    logic               busy_p1;

    // D-1, with out-of-range selections clamped to the deepest tap
    function automatic logic [DLY_W-1:0] clamp_sel(input logic [DLY_W-1:0] s);
        if (32'(s) >= MAX_DLY)
            return DLY_W'(MAX_DLY - 1);
        return s;
    endfunction

    assign in_word = {en_sync_in, cnt_sync_in, din};
    assign d_m1    = clamp_sel(dly_q);
    assign change  = (dly_sel != dly_q);

    // Tap selection: D=1 bypasses the taps so the output register is the only stage.
    always_comb begin
        sel_word = in_word;
        for (int k = 0; k < MAX_DLY - 1; k++) begin
            if (d_m1 == DLY_W'(k + 1))
                sel_word = tap_p0[k];
        end
    end

    always_comb begin
        next_state = state;
        fill_nxt   = fill_cnt;
        if (change) begin
            next_state = FILL;
            fill_nxt   = '0;
        end else if (state == FILL) begin
            if (fill_cnt == d_m1) begin
                next_state = RUN;
                fill_nxt   = '0;
            end else begin
                fill_nxt = fill_cnt + 1'b1;
            end
        end
    end

    // Stage p0: free-running taps, never flushed by a latency change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < MAX_DLY - 1; k++)
                tap_p0[k] <= '0;
        end else begin
            tap_p0[0] <= in_word;
            for (int k = 1; k < MAX_DLY - 1; k++)
                tap_p0[k] <= tap_p0[k-1];
        end
    end

    // Stage p1: control state and output registers, blanked while refilling.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= FILL;
            dly_q    <= '0;
            fill_cnt <= '0;
            out_p1   <= '0;
            busy_p1  <= 1'b1;
        end else begin
            state    <= next_state;
            dly_q    <= dly_sel;
            fill_cnt <= fill_nxt;
            out_p1   <= (next_state == RUN) ? sel_word : '0;
            busy_p1  <= (next_state == FILL);
        end
    end

    assign en_sync_out  = out_p1[TAP_W-1];
    assign cnt_sync_out = out_p1[DW +: CNT_W];
    assign dout         = out_p1[DW-1:0];
    assign dly_busy     = busy_p1;

endmodule

// File: tb/tb_delay_line_align.sv
// Randomized bench for delay_line_align: two instances (MAX_DLY 16 and 12) share inputs
// and are compared each cycle against an edge-indexed history model.
module tb_delay_line_align;

    logic        clk;
    logic        rst;
    logic [3:0]  dly_sel;
    logic        en_in;
    logic [8:0]  cnt_in;
    logic [63:0] din;

    logic        en_out   [2];
    logic [8:0]  cnt_out  [2];
    logic [63:0] dout     [2];
    logic        busy     [2];

    delay_line_align #(.BITWIDTH(7), .DATA_W(16), .NCH(4), .MAX_DLY(16), .DLY_W(4)) dut0 (
        .clk(clk), .rst(rst), .dly_sel(dly_sel), .en_sync_in(en_in),
        .cnt_sync_in(cnt_in), .din(din), .en_sync_out(en_out[0]),
        .cnt_sync_out(cnt_out[0]), .dout(dout[0]), .dly_busy(busy[0])
    );

    delay_line_align #(.BITWIDTH(7), .DATA_W(16), .NCH(4), .MAX_DLY(12), .DLY_W(4)) dut1 (
        .clk(clk), .rst(rst), .dly_sel(dly_sel), .en_sync_in(en_in),
        .cnt_sync_in(cnt_in), .din(din), .en_sync_out(en_out[1]),
        .cnt_sync_out(cnt_out[1]), .dout(dout[1]), .dly_busy(busy[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: inputs are logged per edge; the output after edge e is the sample of
    // edge e-D+1 unless fewer than D edges have elapsed since the last dly_sel change.
    localparam int MAXD [2] = '{16, 12};
    logic        h_en  [0:8191];
    logic [8:0]  h_cnt [0:8191];
    logic [63:0] h_din [0:8191];
    int          edge_n;
    int          m_q   [2];
    int          m_chg [2];
    int          m_d   [2];
    logic        x_en   [2];
    logic [8:0]  x_cnt  [2];
    logic [63:0] x_din  [2];
    logic        x_busy [2];

    task automatic model_reset();
        edge_n = 0;
        for (int i = 0; i < 2; i++) begin
            m_q[i] = 0; m_chg[i] = 0; m_d[i] = 1;
            x_en[i] = 1'b0; x_cnt[i] = '0; x_din[i] = '0; x_busy[i] = 1'b1;
        end
    endtask

    task automatic model_edge();
        int sel;
        int src;
        edge_n++;
        h_en[edge_n] = en_in; h_cnt[edge_n] = cnt_in; h_din[edge_n] = din;
        sel = int'(dly_sel);
        for (int i = 0; i < 2; i++) begin
            if (sel != m_q[i]) begin
                m_chg[i] = edge_n;
                m_d[i]   = ((sel < MAXD[i] - 1) ? sel : MAXD[i] - 1) + 1;
            end
            m_q[i] = sel;
            x_busy[i] = (edge_n - m_chg[i]) < m_d[i];
            if (x_busy[i]) begin
                x_en[i] = 1'b0; x_cnt[i] = '0; x_din[i] = '0;
            end else begin
                src = edge_n - m_d[i] + 1;
                x_en[i] = h_en[src]; x_cnt[i] = h_cnt[src]; x_din[i] = h_din[src];
            end
        end
    endtask

    logic [8:0]  cnt_ctr = '0;
    logic [15:0] ramp    = 16'd1;
    logic [15:0] last_ramp;
    bit          en_rand = 1'b1;

    task automatic cycle();
        cnt_in  = cnt_ctr;
        cnt_ctr = cnt_ctr + 9'd1;
        din     = {$urandom(), $urandom_range(0, 65535), ramp};
        last_ramp = ramp;
        ramp    = ramp + 16'd1;
        if (en_rand) en_in = 1'($urandom_range(0, 1));
        model_edge();
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_val($sformatf("en_out%0d@%0d", i, edge_n), 64'(en_out[i]), 64'(x_en[i]));
            check_val($sformatf("cnt_out%0d@%0d", i, edge_n), 64'(cnt_out[i]), 64'(x_cnt[i]));
            check_val($sformatf("dout%0d@%0d", i, edge_n), dout[i], x_din[i]);
            check_val($sformatf("busy%0d@%0d", i, edge_n), 64'(busy[i]), 64'(x_busy[i]));
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    // Busy cycles on the 16-deep instance following the edge that sees the new dly_sel.
    task automatic fill_len(output int n);
        n = 0;
        cycle();
        while (busy[0] && n < 200) begin
            n++;
            cycle();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < 2; i++) begin
            check_val($sformatf("%s_en%0d", tag, i), 64'(en_out[i]), 64'd0);
            check_val($sformatf("%s_cnt%0d", tag, i), 64'(cnt_out[i]), 64'd0);
            check_val($sformatf("%s_dout%0d", tag, i), dout[i], 64'd0);
            check_val($sformatf("%s_busy%0d", tag, i), 64'(busy[i]), 64'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b0; dly_sel = '0; en_in = 1'b0; cnt_in = '0; din = '0;
        model_reset();
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;

        // D=1 with ramp on channel 0
        en_in = 1'b1; en_rand = 1'b0;
        cycle();
        check_val("busy_after_1_edge", 64'(busy[0]), 64'd0);
        check_val("ch0_d1", 64'(dout[0][15:0]), 64'(last_ramp));
        run(10);
        check_val("ch0_d1_later", 64'(dout[0][15:0]), 64'(last_ramp));
        en_rand = 1'b1;

        // asynchronous reset between edges while in RUN
        #2 rst = 1'b0;
        #1 check_reset_outputs("async_rst");
        #1 rst = 1'b1;
        model_reset();
        dly_sel = 4'd5;
        fill_len(n);
        check_val("fill_len_sel5", 64'(n), 64'd6);
        run(12);

        dly_sel = 4'd2;
        fill_len(n);
        check_val("fill_len_sel2", 64'(n), 64'd3);
        run(10);
        dly_sel = 4'd7;
        fill_len(n);
        check_val("fill_len_sel7", 64'(n), 64'd8);
        run(12);

        // back-to-back changes restart the fill
        dly_sel = 4'd3;
        run(10);
        dly_sel = 4'd4;
        cycle();
        dly_sel = 4'd3;
        fill_len(n);
        check_val("fill_len_toggle", 64'(n), 64'd4);
        run(8);

        // clamp on the 12-deep instance: isolated en pulse
        dly_sel = 4'd15;
        fill_len(n);
        check_val("fill_len_sel15", 64'(n), 64'd16);
        en_rand = 1'b0; en_in = 1'b0;
        run(20);
        en_in = 1'b1;
        cycle();
        en_in = 1'b0;
        n = 0;
        while (!en_out[1] && n < 50) begin
            n++;
            cycle();
        end
        check_val("pulse_delay_clamped", 64'(n), 64'd11);
        en_rand = 1'b1;

        // random latency changes with random data
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 19) == 0)
                dly_sel = 4'($urandom_range(0, 15));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/delay_line_align.md
DELAY_LINE_ALIGN -- requirements
Module: delay_line_align

Interface
REQ-001 SHALL have parameter BITWIDTH, default 7: sync counter width is BITWIDTH+2 bits.
REQ-002 SHALL have parameter DATA_W, default 16: sample width per channel.
REQ-003 SHALL have parameter NCH, default 4: number of data channels.
REQ-004 SHALL have parameter MAX_DLY, default 16: maximum latency in cycles (range 2..64).
REQ-005 SHALL have parameter DLY_W, default 4: width of dly_sel, equal to clog2(MAX_DLY).
REQ-006 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst  input  1: reset, asynchronous, active-low.
REQ-008 SHALL have port dly_sel  input  DLY_W: requested latency minus one.
REQ-009 SHALL have port en_sync_in  input  1: sample-valid / frame sync.
REQ-010 SHALL have port cnt_sync_in  input  BITWIDTH+2: FFT bin/sample counter.
REQ-011 SHALL have port din  input  NCH*DATA_W: packed channels, channel 0 in the LSBs.
REQ-012 SHALL have port en_sync_out  output  1: delayed en_sync_in, gated during fill.
REQ-013 SHALL have port cnt_sync_out  output  BITWIDTH+2: delayed cnt_sync_in.
REQ-014 SHALL have port dout  output  NCH*DATA_W: delayed din, same packing.
REQ-015 SHALL have port dly_busy  output  1: high while the pipeline is refilling.
REQ-016 All outputs SHALL be driven directly from flip-flops.

Function
REQ-017 Effective delay SHALL be D = min(dly_sel, MAX_DLY-1) + 1 cycles; a value sampled at edge t SHALL appear on the outputs after edge t+D-1 (D=1: identical to a single register stage).
REQ-018 en_sync_in, cnt_sync_in and din SHALL be delayed by the same D, without exception; no sample SHALL be dropped or duplicated in RUN.
REQ-019 dly_sel SHALL be registered each cycle into dly_q; a change SHALL be detected when dly_sel != dly_q.
REQ-020 State machine SHALL have two states, FILL and RUN; reset state SHALL be FILL.
REQ-021 In FILL, a fill counter SHALL increment once per cycle; when the counter reaches D-1, the next state SHALL be RUN.
REQ-022 In RUN or FILL, a detected dly_sel change SHALL force FILL with the fill counter cleared; this change SHALL take priority over the RUN transition in the same cycle.
REQ-023 The new D SHALL take effect on the cycle after the change is detected; the delay taps SHALL keep shifting (no flush of the stored data).
REQ-024 dly_busy SHALL be 1 exactly while in FILL.
REQ-025 In FILL, en_sync_out, cnt_sync_out and dout SHALL be registered to 0; in RUN they SHALL carry the tap data.
REQ-026 dly_sel values >= MAX_DLY (possible only when MAX_DLY is not a power of two) SHALL clamp to MAX_DLY-1.
REQ-027 cnt_sync values SHALL pass unmodified, with no wrap or arithmetic applied.

Reset
REQ-028 On rst low, immediately and independent of clk: all delay stages, dout, cnt_sync_out, en_sync_out, dly_q and the fill counter SHALL be 0; state SHALL be FILL; dly_busy SHALL be 1.
REQ-029 Reset assertion mid-operation SHALL discard all in-flight samples.
REQ-030 After rst rises, operation SHALL begin on the first rising edge of clk; a nonzero dly_sel SHALL then count as a change (dly_q=0).

Verification
REQ-031 dly_sel=0, rst released, din ramp 1,2,3.. with en_sync_in=1 -> RUN after 1 edge; dout channel 0 = din delayed exactly 1 cycle; dly_busy low from cycle 2.
REQ-032 dly_sel=5 from reset, cnt_sync_in counting 0..511 -> dly_busy high for 6 cycles (1 detect + 5 fill); thereafter cnt_sync_out = cnt_sync_in delayed 6 cycles; en_sync_out = 0 throughout FILL.
REQ-033 In RUN with dly_sel=2, change to 7 -> dly_busy=1 for 8 cycles with all outputs 0, then 8-cycle latency, with bitwise match on all NCH channels.
REQ-034 dly_sel toggled 3->4->3 on consecutive cycles -> fill counter restarts at each change; RUN is reached only 4 cycles after the last change.
REQ-035 MAX_DLY=12, dly_sel=15 -> D=12 (clamped); an isolated en_sync_in pulse reappears exactly 12 cycles later.
REQ-036 rst pulsed low asynchronously between edges during RUN -> all outputs 0 with no clock edge; on release, the FILL sequence is repeated per REQ-030.
